// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types for the cache-side bus and its arbiter.
// Contents: request/response payloads, burst length and type enums, and the
// arbiter state encoding.
package cbus_arbiter_pkg;

    localparam int unsigned CBUS_ADDR_W = 32;
    localparam int unsigned CBUS_DATA_W = 32;
    localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

    // Burst length encoded as beats-1
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [2:0]             size;
        mlen_t                  len;
        axi_burst_type_t        burst;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_STRB_W-1:0] strb;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } cbus_arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Round-robin picker: first set bit of `valid` scanning upward from `prio`,
// wrapping modulo NUM_PORTS. Purely combinational.
// Ports:
//   valid  [NUM_PORTS-1:0]  request vector
//   prio   [IDX_W-1:0]      index that has highest priority (< NUM_PORTS)
//   found                   some request is set
//   index  [IDX_W-1:0]      winning index (0 when nothing is found)
module cbus_arbiter_rr_pick #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IDX_W-1:0]     prio,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    int unsigned pos;

    // Walk from the lowest priority upward so the highest-priority hit is written last
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = 0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            pos = 32'(prio) + 32'(i);
            if (pos >= NUM_PORTS) begin
                pos = pos - NUM_PORTS;
            end
            if (valid[IDX_W'(pos)]) begin
                found = 1'b1;
                index = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 round-robin arbiter between cbus masters and the single cbus port
// feeding the AXI bridge. The grant is registered and held until the beat
// with ready && last; the granted request is forwarded live and the response
// is routed back only to the granted master.
// Ports:
//   clk     system clock, rising edge
//   resetn  synchronous active-low reset
//   ireqs   upstream requests, one per master (index 0 = icache)
//   iresps  per-master responses ('0 for non-granted masters)
//   oreq    request to the AXI bridge ('0 when no grant)
//   oresp   response from the AXI bridge
//   busy    high while a burst is granted
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireqs  [NUM_PORTS],
    output cbus_resp_t iresps [NUM_PORTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       busy
);

    cbus_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     prio_q, prio_d;
    logic [IDX_W-1:0]     next_prio;
    logic [NUM_PORTS-1:0] valid_vec;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_valid
        assign valid_vec[g] = ireqs[g].valid;
    end

    cbus_arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .valid (valid_vec),
        .prio  (prio_q),
        .found (pick_found),
        .index (pick_idx)
    );

    // State, grant index and round-robin pointer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
        end
    end

    // Next state and the request/response muxes; outputs forced quiet while in reset
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        prio_d    = prio_q;
        oreq      = '0;
        iresps    = '{default: '0};
        busy      = 1'b0;
        next_prio = (sel_q == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_q + IDX_W'(1);

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_BUSY;
                    sel_d   = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (resetn) begin
                    oreq          = ireqs[sel_q];
                    iresps[sel_q] = oresp;
                    busy          = 1'b1;
                end
                if (oresp.ready && oresp.last) begin
                    state_d = ARB_IDLE;
                    prio_d  = next_prio;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with two masters: a per-cycle vector table
// for reset, contention and idle behaviour, then hand-written sequences for a
// 16-beat read, write data pass-through, late arrival and reset mid-burst.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int unsigned NP = 2;

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  ireqs  [NP];
    cbus_resp_t iresps [NP];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // g: expected grant, 0 = none, 1 = port 0, 2 = port 1
    typedef struct {
        logic rst;
        logic v0;
        logic v1;
        logic rdy;
        logic lst;
        int   g;
    } vec_t;

    vec_t tbl [24];

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_PORTS(NP)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp),
        .busy   (busy)
    );

    // Master/bridge protocol the bench itself must respect
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (busy) assert (oreq.valid) else $error("granted master dropped valid mid-burst");
            if (!busy) assert (!oresp.ready) else $error("bridge response while arbiter idle");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic apply(input logic rst, input logic v0, input logic v1,
                         input logic rdy, input logic lst);
        @(posedge clk);
        #1;
        resetn         = rst;
        ireqs[0].valid = v0;
        ireqs[1].valid = v1;
        oresp.ready    = rdy;
        oresp.last     = lst;
        oresp.data     = 32'hD000_0000 + 32'(cyc);
        cyc++;
    endtask

    task automatic check(input int g, input string name);
        cbus_req_t  eo;
        cbus_resp_t e0, e1;
        @(negedge clk);
        eo = '0;
        e0 = '0;
        e1 = '0;
        if (g == 1) begin
            eo = ireqs[0];
            e0 = oresp;
        end else if (g == 2) begin
            eo = ireqs[1];
            e1 = oresp;
        end
        n_cmp++;
        if (busy !== (g != 0)) begin
            n_err++;
            $display("FAIL %s busy: got %b want %b", name, busy, (g != 0));
        end
        n_cmp++;
        if (oreq !== eo) begin
            n_err++;
            $display("FAIL %s oreq: got %h want %h", name, oreq, eo);
        end
        n_cmp++;
        if (iresps[0] !== e0) begin
            n_err++;
            $display("FAIL %s iresps0: got %h want %h", name, iresps[0], e0);
        end
        n_cmp++;
        if (iresps[1] !== e1) begin
            n_err++;
            $display("FAIL %s iresps1: got %h want %h", name, iresps[1], e1);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        oresp    = '0;
        ireqs[0] = '0;
        ireqs[1] = '0;
        ireqs[0].addr  = 32'h8000_0000;
        ireqs[0].size  = 3'd2;
        ireqs[0].len   = MLEN4;
        ireqs[0].burst = AXI_BURST_INCR;
        ireqs[1].addr  = 32'h9000_0000;
        ireqs[1].size  = 3'd2;
        ireqs[1].len   = MLEN4;
        ireqs[1].burst = AXI_BURST_INCR;

        // rst, v0, v1, rdy, lst, expected grant
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].rdy, tbl[i].lst);
            check(tbl[i].g, $sformatf("vec%0d", i));
        end

        // 16-beat read on port 0 from prio 0
        ireqs[0].len = MLEN16;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check(0, "a_idle");
        for (int b = 0; b < 16; b++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, (b == 15));
            check(1, $sformatf("a_beat%0d", b));
        end

        // prio is now 1: port 1 wins a tie and streams write data per beat
        ireqs[1].is_write = 1'b1;
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check(0, "b_gap");
        for (int b = 0; b < 4; b++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, (b == 3));
            ireqs[1].data = 32'h11 * 32'(b + 1);
            ireqs[1].strb = 4'b0001 << b;
            check(2, $sformatf("b_beat%0d", b));
            n_cmp++;
            if (oreq.data !== 32'h11 * 32'(b + 1) || oreq.strb !== (4'b0001 << b)) begin
                n_err++;
                $display("FAIL b_wdata%0d: got data %h strb %b want data %h strb %b",
                         b, oreq.data, oreq.strb, 32'h11 * 32'(b + 1), 4'b0001 << b);
            end
        end

        // Port 1 raised while port 0 busy; port 0 keeps asking but port 1 goes next
        ireqs[0].len      = MLEN4;
        ireqs[1].is_write = 1'b0;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check(0, "c_idle");
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check(1, "c_beat0");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check(1, "c_beat1");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check(1, "c_beat2");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check(1, "c_beat3");
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check(0, "c_gap");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check(2, "c_late_grant");

        // Single beat on port 0 moves prio to 1, then port 1 is reset mid-burst
        ireqs[0].len = MLEN1;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check(0, "d_idle");
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check(1, "d_single");
        ireqs[1].len = MLEN16;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check(0, "d_gap");
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check(2, "d_beat0");
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check(2, "d_beat1");
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check(0, "d_reset_beat2");
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check(0, "d_after_reset");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check(1, "d_prio_reset");
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check(0, "end_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
